// File: rtl/binarize_pkg.sv
// rtl/binarize_pkg.sv - shared types and constants for the binarizing frame-buffer writer
package binarize_pkg;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_t;

    localparam logic [7:0] LUMA_COEF_R = 8'd77;
    localparam logic [7:0] LUMA_COEF_G = 8'd150;
    localparam logic [7:0] LUMA_COEF_B = 8'd29;

    localparam int RGB_R_MSB = 15;
    localparam int RGB_R_LSB = 11;
    localparam int RGB_G_MSB = 10;
    localparam int RGB_G_LSB = 5;
    localparam int RGB_B_MSB = 4;
    localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/rgb565_to_luma.sv
// rtl/rgb565_to_luma.sv - RGB565 to 8-bit luma, one registered stage
module rgb565_to_luma
    import binarize_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_rgb,
    output logic [7:0]  o_y
);

    logic [4:0]  w_r5;
    logic [5:0]  w_g6;
    logic [4:0]  w_b5;
    logic [7:0]  w_r8;
    logic [7:0]  w_g8;
    logic [7:0]  w_b8;
    logic [15:0] w_sum;

    assign w_r5 = i_rgb[RGB_R_MSB:RGB_R_LSB];
    assign w_g6 = i_rgb[RGB_G_MSB:RGB_G_LSB];
    assign w_b5 = i_rgb[RGB_B_MSB:RGB_B_LSB];

    // Replicate MSBs so full-scale 565 maps to 255 in each channel
    assign w_r8 = {w_r5, w_r5[4:2]};
    assign w_g8 = {w_g6, w_g6[5:4]};
    assign w_b8 = {w_b5, w_b5[4:2]};

    // Coefficients sum to 256, so the 16-bit sum cannot overflow
    assign w_sum = 16'(w_r8) * 16'(LUMA_COEF_R)
                 + 16'(w_g8) * 16'(LUMA_COEF_G)
                 + 16'(w_b8) * 16'(LUMA_COEF_B);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_y <= 8'd0;
        end else begin
            o_y <= w_sum[15:8];
        end
    end

endmodule

// File: rtl/binarize_fb_writer.sv
// rtl/binarize_fb_writer.sv - camera pixels to 1-bit frame-buffer writes; optional BIN_AUTO_THRESH_EN
module binarize_fb_writer
    import binarize_pkg::*;
#(
    parameter int IMG_W  = 800,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
)(
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              pix_sof,
    input  logic [15:0]       pix_data,
    input  logic [7:0]        thresh_i,
    input  logic              frame_hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              frame_done,
    output logic              err_short
);

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_accept;
    logic              w_wr;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic              w_err;

    logic              r_s1_valid;
    logic [ADDR_W-1:0] r_s1_addr;
    logic              r_s1_last;
    logic              r_s1_err;
    logic [7:0]        w_y;
    logic [7:0]        w_thresh;

    assign pix_ready = nRST;
    assign w_accept  = pix_valid & pix_ready;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_WAIT_SOF;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr        = 1'b0;
        w_addr      = r_cnt;
        w_last      = 1'b0;
        w_err       = 1'b0;
        if (w_accept) begin
            case (r_state)
                ST_WAIT_SOF: begin
                    if (pix_sof && !frame_hold) begin
                        w_wr        = 1'b1;
                        w_addr      = '0;
                        w_cnt_nxt   = ADDR_W'(1);
                        w_state_nxt = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (pix_sof) begin
                        // Early SOF: truncated frame, restart or stop if held
                        if (frame_hold) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_WAIT_SOF;
                        end else begin
                            w_wr      = 1'b1;
                            w_err     = 1'b1;
                            w_addr    = '0;
                            w_cnt_nxt = ADDR_W'(1);
                        end
                    end else begin
                        w_wr = 1'b1;
                        if (r_cnt == LAST_ADDR) begin
                            w_last      = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_WAIT_SOF;
                        end else begin
                            w_cnt_nxt = r_cnt + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_WAIT_SOF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    rgb565_to_luma u_luma (
        .i_clk   (PixelClk),
        .i_rst_n (nRST),
        .i_rgb   (pix_data),
        .o_y     (w_y)
    );

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_last  <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_wr;
            r_s1_addr  <= w_addr;
            r_s1_last  <= w_last;
            r_s1_err   <= w_err;
        end
    end

`ifdef BIN_AUTO_THRESH_EN
    logic [7:0] r_thr;
    logic       r_thr_vld;
    logic [7:0] r_min;
    logic [7:0] r_max;
    logic       w_first;
    logic [7:0] w_min_nxt;
    logic [7:0] w_max_nxt;
    logic [8:0] w_mid;

    // Address 0 marks the first pixel of a frame, including a restart
    assign w_first   = (r_s1_addr == '0);
    assign w_min_nxt = (w_first || (w_y < r_min)) ? w_y : r_min;
    assign w_max_nxt = (w_first || (w_y > r_max)) ? w_y : r_max;
    assign w_mid     = 9'(w_min_nxt) + 9'(w_max_nxt);
    assign w_thresh  = r_thr_vld ? r_thr : thresh_i;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            r_thr     <= 8'd0;
            r_thr_vld <= 1'b0;
            r_min     <= 8'd0;
            r_max     <= 8'd0;
        end else if (r_s1_valid) begin
            r_min <= w_min_nxt;
            r_max <= w_max_nxt;
            if (r_s1_last) begin
                r_thr     <= w_mid[8:1];
                r_thr_vld <= 1'b1;
            end
        end
    end
`else
    assign w_thresh = thresh_i;
`endif

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
        end else begin
            wr_en      <= r_s1_valid;
            frame_done <= r_s1_valid & r_s1_last;
            err_short  <= r_s1_valid & r_s1_err;
            if (r_s1_valid) begin
                wr_addr <= r_s1_addr;
                wr_data <= (w_y >= w_thresh);
            end
        end
    end

endmodule
